// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit adder/subtractor whose carry chain is cut into
// STAGES = WIDTH/SLICE register stages, one SLICE-bit chunk per stage.
// Valid/ready handshakes on both sides; one beat per clock when not stalled.
// WIDTH must be a whole multiple of SLICE.
module adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             cy,
  output logic             ov
);

  localparam int STAGES = WIDTH / SLICE;

  // The whole pipe moves as one: it advances unless a finished result is
  // waiting on a downstream that is not ready.  Bubbles are not collapsed.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added on entry to this stage (incl. its slice)
    localparam int OPW = WIDTH - k * SLICE;
    // Result bits known once this stage has added its slice
    localparam int LOW = (k + 1) * SLICE;

    logic             v_in;
    logic             c_in;
    logic [OPW-1:0]   a_in;
    logic [OPW-1:0]   b_in;
    logic [LOW-1:0]   s_next;
    logic [SLICE:0]   slice_sum;

    logic             v_q;
    logic             c_q;
    logic [LOW-1:0]   s_q;

    if (k == 0) begin : g_head
      // Subtraction is A + ~B + 1; carry-in is forced to 1 and in_cin ignored.
      assign v_in   = in_valid;
      assign c_in   = in_sub ? 1'b1 : in_cin;
      assign a_in   = in_data1;
      assign b_in   = in_sub ? ~in_data2 : in_data2;
      assign s_next = slice_sum[SLICE-1:0];
    end else begin : g_body
      assign v_in   = g_stage[k-1].v_q;
      assign c_in   = g_stage[k-1].c_q;
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign s_next = {slice_sum[SLICE-1:0], g_stage[k-1].s_q};
    end

    // The lowest remaining operand bits always belong to this stage's slice.
    assign slice_sum = {1'b0, a_in[SLICE-1:0]} + {1'b0, b_in[SLICE-1:0]}
                     + {{SLICE{1'b0}}, c_in};

    // Stage register: valid follows the pipe; data loads only with a real
    // beat so that output data never changes while no result is presented.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its neighbour's pre-edge value and the pipe shifts cleanly.
      if (rst) begin
        // NOTE: data registers are reset as well, because the last stage
        // drives out_data/cy and those must read 0 after reset.
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= slice_sum[SLICE];
          s_q <= s_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OPW-SLICE-1:0] a_q;
      logic [OPW-SLICE-1:0] b_q;

      // Carry the not-yet-added operand slices forward to the next stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_in) begin
          a_q <= a_in[OPW-1:SLICE];
          b_q <= b_in[OPW-1:SLICE];
        end
      end
    end else begin : g_tail
      logic ov_q;

      // Signed overflow: carry into MSB (recovered as a^b^sum at the MSB)
      // XOR carry out of MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          ov_q <= 1'b0;
        end else if (adv && v_in) begin
          ov_q <= slice_sum[SLICE] ^ a_in[OPW-1] ^ b_in[OPW-1] ^ slice_sum[SLICE-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_data  = g_stage[STAGES-1].s_q;
  assign cy        = g_stage[STAGES-1].c_q;
  assign ov        = g_stage[STAGES-1].g_tail.ov_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed, self-checking bench for adder_pipe.  A 16-bit,
// 4-stage instance covers arithmetic, latency, streaming with a stall and
// reset; a 4-bit single-stage instance covers the STAGES=1 corner.
module tb_adder_pipe;

  logic clk;
  logic rst;

  // 16-bit / 4-stage instance
  logic        iv16, ir16, cin16, sub16, ov_v16, or16, cy16, of16;
  logic [15:0] d1_16, d2_16, q16;

  // 4-bit / 1-stage instance
  logic        iv4, ir4, cin4, sub4, ov_v4, or4, cy4, of4;
  logic [3:0]  d1_4, d2_4, q4;

  int n_total = 0;
  int n_bad   = 0;

  // Streaming vectors (add, cin=0) with hand-computed results
  localparam logic [15:0] SA [6] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF, 16'h8000, 16'h8001};
  localparam logic [15:0] SB [6] = '{16'h0002, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000, 16'h8001};
  localparam logic [15:0] SE [6] = '{16'h0003, 16'h0100, 16'h1000, 16'hFFFE, 16'h0000, 16'h0002};
  localparam logic        SC [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic        SO [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  adder_pipe #(.WIDTH(16), .SLICE(4)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .in_data1  (d1_16),
    .in_data2  (d2_16),
    .in_cin    (cin16),
    .in_sub    (sub16),
    .out_valid (ov_v16),
    .out_ready (or16),
    .out_data  (q16),
    .cy        (cy16),
    .ov        (of16)
  );

  adder_pipe #(.WIDTH(4), .SLICE(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .in_data1  (d1_4),
    .in_data2  (d2_4),
    .in_cin    (cin4),
    .in_sub    (sub4),
    .out_valid (ov_v4),
    .out_ready (or4),
    .out_data  (q4),
    .cy        (cy4),
    .ov        (of4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One isolated beat through the 16-bit pipe; measures accept-to-valid edges.
  task automatic send16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input logic [15:0] e_data,
                        input logic e_cy, input logic e_ov);
    int lat;
    @(negedge clk);
    d1_16 = a; d2_16 = b; cin16 = cin; sub16 = sub; iv16 = 1'b1;
    check({tag, "_rdy"}, 32'(ir16), 32'd1);
    @(negedge clk);
    iv16 = 1'b0;
    lat  = 1;
    while (!ov_v16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_data"}, 32'(q16), 32'(e_data));
    check({tag, "_cy"}, 32'(cy16), 32'(e_cy));
    check({tag, "_ov"}, 32'(of16), 32'(e_ov));
  endtask

  // One isolated beat through the single-stage 4-bit pipe.
  task automatic send4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic sub, input logic [3:0] e_data,
                       input logic e_cy, input logic e_ov);
    int lat;
    @(negedge clk);
    d1_4 = a; d2_4 = b; cin4 = 1'b0; sub4 = sub; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    lat = 1;
    while (!ov_v4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_data"}, 32'(q4), 32'(e_data));
    check({tag, "_cy"}, 32'(cy4), 32'(e_cy));
    check({tag, "_ov"}, 32'(of4), 32'(e_ov));
  endtask

  initial begin
    int tx;
    int rx;
    int ghosts;

    rst = 1'b1;
    iv16 = 1'b0; d1_16 = '0; d2_16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    iv4  = 1'b0; d1_4  = '0; d2_4  = '0; cin4  = 1'b0; sub4  = 1'b0; or4  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_vld", 32'(ov_v16), 32'd0);
    check("rst_data", 32'(q16), 32'd0);
    check("rst_cy", 32'(cy16), 32'd0);
    check("rst_ov", 32'(of16), 32'd0);
    check("rst_rdy", 32'(ir16), 32'd1);
    check("rst_vld4", 32'(ov_v4), 32'd0);

    // Addition
    send16("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send16("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send16("add_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Subtraction (cy=1 means no borrow); in_cin must be ignored
    send16("sub_3_5",    16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send16("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send16("sub_cin_ign", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send16("sub_eq",     16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Stream six beats back to back; downstream stalls for three cycles
    tx = 0;
    rx = 0;
    for (int c = 0; c < 40 && rx < 6; c++) begin
      @(negedge clk);
      or16  = !(c >= 4 && c <= 6);
      iv16  = (tx < 6);
      cin16 = 1'b0;
      sub16 = 1'b0;
      if (tx < 6) begin
        d1_16 = SA[tx];
        d2_16 = SB[tx];
      end
      #1;
      if (c >= 4) check("strm_vld", 32'(ov_v16), 32'd1);
      if (c >= 4 && c <= 6) begin
        check("stall_rdy", 32'(ir16), 32'd0);
        check("stall_data", 32'(q16), 32'(SE[rx]));
        check("stall_cy", 32'(cy16), 32'(SC[rx]));
        check("stall_ov", 32'(of16), 32'(SO[rx]));
      end
      if (ov_v16 && or16) begin
        check("strm_data", 32'(q16), 32'(SE[rx]));
        check("strm_cy", 32'(cy16), 32'(SC[rx]));
        check("strm_ov", 32'(of16), 32'(SO[rx]));
        rx++;
      end
      if (iv16 && ir16) tx++;
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    check("strm_rx", 32'(rx), 32'd6);
    check("strm_tx", 32'(tx), 32'd6);

    // Reset mid-flight: two beats accepted, then rst for one cycle
    @(negedge clk);
    @(negedge clk);
    d1_16 = 16'h1111; d2_16 = 16'h1111; iv16 = 1'b1;
    @(negedge clk);
    d1_16 = 16'h2222; d2_16 = 16'h2222;
    @(negedge clk);
    iv16 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_vld", 32'(ov_v16), 32'd0);
    check("mrst_data", 32'(q16), 32'd0);
    check("mrst_cy", 32'(cy16), 32'd0);
    check("mrst_ov", 32'(of16), 32'd0);
    ghosts = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov_v16) ghosts++;
    end
    check("mrst_ghost", 32'(ghosts), 32'd0);
    send16("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Single-stage instance
    send4("w4_0p1", 4'h0, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0);
    send4("w4_1p1", 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0);
    send4("w4_1p3", 4'h1, 4'h3, 1'b0, 4'h4, 1'b0, 1'b0);
    send4("w4_fp1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    send4("w4_ep1", 4'hE, 4'h1, 1'b0, 4'hF, 1'b0, 1'b0);
    send4("w4_7p1", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    send4("w4_2m3", 4'h2, 4'h3, 1'b1, 4'hF, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
